mbscore_int_requester: RTL and testbench

MBSCORE_INT_REQUESTER -- requirements
Module: MBScore_int_requester

---
 rtl/mbscore_int_requester_pkg.sv | 32 +++
 rtl/mbscore_int_prio_enc.sv | 14 +
 rtl/mbscore_int_requester.sv | 117 +++++++++++
 tb/tb_mbscore_int_requester.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbscore_int_requester_pkg.sv
// Shared constants for the MBScore interrupt requester: source indices,
// one-hot source vectors and the requester state encoding.
package mbscore_int_requester_pkg;

    localparam int unsigned NUM_SRC_DEF     = 7;
    localparam int unsigned ACK_TIMEOUT_DEF = 15;

    // Source bit indices, bit 0 is the highest priority
    localparam int unsigned SRC_SYSCALL  = 0;
    localparam int unsigned SRC_KEYBOARD = 1;
    localparam int unsigned SRC_MOUSE    = 2;
    localparam int unsigned SRC_UART     = 3;
    localparam int unsigned SRC_STORAGE  = 4;
    localparam int unsigned SRC_ETHERNET = 5;
    localparam int unsigned SRC_CF       = 6;

    // One-hot request vectors as seen by the interrupt controller
    localparam logic [NUM_SRC_DEF-1:0] INT_SYSCALL  = NUM_SRC_DEF'(1) << SRC_SYSCALL;
    localparam logic [NUM_SRC_DEF-1:0] INT_KEYBOARD = NUM_SRC_DEF'(1) << SRC_KEYBOARD;
    localparam logic [NUM_SRC_DEF-1:0] INT_MOUSE    = NUM_SRC_DEF'(1) << SRC_MOUSE;
    localparam logic [NUM_SRC_DEF-1:0] INT_UART     = NUM_SRC_DEF'(1) << SRC_UART;
    localparam logic [NUM_SRC_DEF-1:0] INT_STORAGE  = NUM_SRC_DEF'(1) << SRC_STORAGE;
    localparam logic [NUM_SRC_DEF-1:0] INT_ETHERNET = NUM_SRC_DEF'(1) << SRC_ETHERNET;
    localparam logic [NUM_SRC_DEF-1:0] INT_CF       = NUM_SRC_DEF'(1) << SRC_CF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/mbscore_int_prio_enc.sv
// Fixed-priority encoder: isolates the lowest set pending bit as a one-hot.
module mbscore_int_prio_enc #(
    parameter int unsigned W = 7
) (
    input  logic [W-1:0] i_pending,
    output logic [W-1:0] o_onehot
);

    // x & -x keeps only the least significant set bit; zero in gives zero out
    always_comb begin
        o_onehot = i_pending & (~i_pending + W'(1));
    end

endmodule

// File: rtl/mbscore_int_requester.sv
// Interrupt requester: latches device request edges, presents one source at
// a time to the interrupt controller and tracks the handler until EOI.
module mbscore_int_requester
    import mbscore_int_requester_pkg::*;
#(
    parameter int unsigned NUM_SRC     = NUM_SRC_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] dev_req,
    input  logic               int_en_n,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [NUM_SRC-1:0] int_vec,
    output logic [NUM_SRC-1:0] int_pending,
    output logic               int_busy
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e             r_state;
    state_e             w_state_nxt;
    logic [NUM_SRC-1:0] r_dev_req;
    logic [NUM_SRC-1:0] r_dev_req_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_vec;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_vec_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign int_vec     = r_vec;
    assign int_pending = r_pending;
    assign int_busy    = r_busy;

    // Edge is judged on the synchronised copy so a raw glitch cannot race the grant
    assign w_rise = r_dev_req & ~r_dev_req_d;

    mbscore_int_prio_enc #(
        .W (NUM_SRC)
    ) u_prio_enc (
        .i_pending (r_pending),
        .o_onehot  (w_grant)
    );

    // Next state, next vector, ack clear mask and timeout counter
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                w_vec_nxt = '0;
                w_cnt_nxt = '0;
                if ((r_pending != '0) && !int_en_n) begin
                    w_state_nxt = ST_REQ;
                    w_vec_nxt   = w_grant;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_clr       = r_vec;
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (int_en_n || (r_cnt == CNT_LAST)) begin
                    // Withdraw but keep pending so the source is offered again
                    w_state_nxt = ST_IDLE;
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SERVICE: begin
                w_vec_nxt = '0;
                if (int_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_vec_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, synchroniser and output registers; a new edge beats an ack clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dev_req   <= dev_req;
            r_dev_req_d <= dev_req;
            r_pending   <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dev_req   <= dev_req;
            r_dev_req_d <= r_dev_req;
            r_pending   <= (r_pending & ~w_clr) | w_rise;
            r_vec       <= w_vec_nxt;
            r_busy      <= (w_state_nxt == ST_SERVICE);
            r_cnt       <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mbscore_int_requester.sv
// Directed bench for the interrupt requester; cycle 0 is the cycle in which
// the device line is first driven, outputs are read 1 time unit after each edge.
module tb_mbscore_int_requester;

    logic       clk;
    logic       rst;
    logic [6:0] dev_req;
    logic       int_en_n;
    logic       int_ack;
    logic       int_eoi;
    logic [6:0] int_vec;
    logic [6:0] int_pending;
    logic       int_busy;

    int n_err;
    int n_chk;

    mbscore_int_requester #(
        .NUM_SRC     (7),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dev_req     (dev_req),
        .int_en_n    (int_en_n),
        .int_ack     (int_ack),
        .int_eoi     (int_eoi),
        .int_vec     (int_vec),
        .int_pending (int_pending),
        .int_busy    (int_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next cycle; outputs are stable for reading afterwards
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge the current grant, then return from the handler
    task automatic serve();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        cyc();
        int_eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dev_req = 7'b0000011; int_en_n = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
        cyc();
        cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL rst_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL rst_pending: got %b want %b", int_pending, 7'b0); end
        n_chk++; if (int_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", int_busy); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL rst_level_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL rst_level_pending: got %b want %b", int_pending, 7'b0); end
        dev_req = 7'b0;
        cyc();
        cyc();
        cyc();
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL fall_no_event: got %b want %b", int_pending, 7'b0); end
    endtask

    task automatic test_latency();
        dev_req = 7'b0000010;
        cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL lat_c1_vec: got %b want %b", int_vec, 7'b0); end
        cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL lat_c2_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0000010) begin n_err++; $display("FAIL lat_c2_pending: got %b want %b", int_pending, 7'b0000010); end
        cyc();
        n_chk++; if (int_vec !== 7'b0000010) begin n_err++; $display("FAIL lat_c3_vec: got %b want %b", int_vec, 7'b0000010); end
        cyc();
        n_chk++; if (int_vec !== 7'b0000010) begin n_err++; $display("FAIL lat_c4_vec: got %b want %b", int_vec, 7'b0000010); end
        n_chk++; if (int_busy !== 1'b0) begin n_err++; $display("FAIL lat_c4_busy: got %b want 0", int_busy); end
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL lat_c5_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_busy !== 1'b1) begin n_err++; $display("FAIL lat_c5_busy: got %b want 1", int_busy); end
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL lat_c5_pending: got %b want %b", int_pending, 7'b0); end
        cyc();
        n_chk++; if (int_busy !== 1'b1) begin n_err++; $display("FAIL lat_c6_busy_hold: got %b want 1", int_busy); end
        int_eoi = 1'b1;
        cyc();
        int_eoi = 1'b0;
        n_chk++; if (int_busy !== 1'b0) begin n_err++; $display("FAIL lat_eoi_busy: got %b want 0", int_busy); end
        dev_req = 7'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_priority();
        dev_req = 7'b1001000;
        cyc();
        cyc();
        cyc();
        n_chk++; if (int_vec !== 7'b0001000) begin n_err++; $display("FAIL prio_first_vec: got %b want %b", int_vec, 7'b0001000); end
        n_chk++; if (int_pending !== 7'b1001000) begin n_err++; $display("FAIL prio_pending: got %b want %b", int_pending, 7'b1001000); end
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_chk++; if (int_pending !== 7'b1000000) begin n_err++; $display("FAIL prio_after_ack: got %b want %b", int_pending, 7'b1000000); end
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL prio_svc_vec: got %b want %b", int_vec, 7'b0); end
        int_eoi = 1'b1;
        cyc();
        int_eoi = 1'b0;
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL prio_idle_vec: got %b want %b", int_vec, 7'b0); end
        cyc();
        n_chk++; if (int_vec !== 7'b1000000) begin n_err++; $display("FAIL prio_second_vec: got %b want %b", int_vec, 7'b1000000); end
        // EOI while requesting must be ignored
        int_eoi = 1'b1;
        cyc();
        int_eoi = 1'b0;
        n_chk++; if (int_vec !== 7'b1000000) begin n_err++; $display("FAIL prio_eoi_ignored: got %b want %b", int_vec, 7'b1000000); end
        serve();
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL prio_drained: got %b want %b", int_pending, 7'b0); end
        dev_req = 7'b0;
        cyc();
        cyc();
    endtask

    task automatic test_timeout();
        dev_req = 7'b0010000;
        cyc();
        cyc();
        cyc();
        for (int c = 3; c <= 17; c++) begin
            n_chk++; if (int_vec !== 7'b0010000) begin n_err++; $display("FAIL to_hold_c%0d: got %b want %b", c, int_vec, 7'b0010000); end
            if (c < 17) cyc();
        end
        cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL to_drop_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0010000) begin n_err++; $display("FAIL to_pending_kept: got %b want %b", int_pending, 7'b0010000); end
        n_chk++; if (int_busy !== 1'b0) begin n_err++; $display("FAIL to_busy: got %b want 0", int_busy); end
        cyc();
        n_chk++; if (int_vec !== 7'b0010000) begin n_err++; $display("FAIL to_represent: got %b want %b", int_vec, 7'b0010000); end
        serve();
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL to_drained: got %b want %b", int_pending, 7'b0); end
        dev_req = 7'b0;
        cyc();
        cyc();
    endtask

    task automatic test_stable_and_withdraw();
        dev_req = 7'b0010000;
        cyc();
        cyc();
        cyc();
        n_chk++; if (int_vec !== 7'b0010000) begin n_err++; $display("FAIL stab_grant: got %b want %b", int_vec, 7'b0010000); end
        dev_req = 7'b0010001;
        cyc();
        cyc();
        n_chk++; if (int_vec !== 7'b0010000) begin n_err++; $display("FAIL stab_hold: got %b want %b", int_vec, 7'b0010000); end
        n_chk++; if (int_pending !== 7'b0010001) begin n_err++; $display("FAIL stab_pending: got %b want %b", int_pending, 7'b0010001); end
        int_en_n = 1'b1;
        cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL wd_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0010001) begin n_err++; $display("FAIL wd_pending: got %b want %b", int_pending, 7'b0010001); end
        cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL wd_masked_vec: got %b want %b", int_vec, 7'b0); end
        int_en_n = 1'b0;
        cyc();
        n_chk++; if (int_vec !== 7'b0000001) begin n_err++; $display("FAIL wd_regrant: got %b want %b", int_vec, 7'b0000001); end
        serve();
        cyc();
        n_chk++; if (int_vec !== 7'b0010000) begin n_err++; $display("FAIL wd_next: got %b want %b", int_vec, 7'b0010000); end
        serve();
        dev_req = 7'b0;
        cyc();
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL wd_drained: got %b want %b", int_pending, 7'b0); end
        cyc();
    endtask

    task automatic test_mask();
        int_en_n = 1'b1;
        dev_req  = 7'b0000100;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL mask_vec_c%0d: got %b want %b", c, int_vec, 7'b0); end
        end
        n_chk++; if (int_pending !== 7'b0000100) begin n_err++; $display("FAIL mask_pending: got %b want %b", int_pending, 7'b0000100); end
        int_en_n = 1'b0;
        cyc();
        n_chk++; if (int_vec !== 7'b0000100) begin n_err++; $display("FAIL mask_release: got %b want %b", int_vec, 7'b0000100); end
        serve();
        dev_req = 7'b0;
        cyc();
        cyc();
    endtask

    task automatic test_set_wins();
        dev_req = 7'b0000001;
        cyc();
        dev_req = 7'b0;
        cyc();
        cyc();
        n_chk++; if (int_vec !== 7'b0000001) begin n_err++; $display("FAIL sw_grant: got %b want %b", int_vec, 7'b0000001); end
        cyc();
        dev_req = 7'b0000001;
        cyc();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_chk++; if (int_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy: got %b want 1", int_busy); end
        n_chk++; if (int_pending !== 7'b0000001) begin n_err++; $display("FAIL sw_pending_kept: got %b want %b", int_pending, 7'b0000001); end
        int_eoi = 1'b1;
        cyc();
        int_eoi = 1'b0;
        cyc();
        n_chk++; if (int_vec !== 7'b0000001) begin n_err++; $display("FAIL sw_second_req: got %b want %b", int_vec, 7'b0000001); end
        serve();
        dev_req = 7'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid();
        dev_req = 7'b0010000;
        cyc();
        cyc();
        cyc();
        n_chk++; if (int_vec !== 7'b0010000) begin n_err++; $display("FAIL rm_grant: got %b want %b", int_vec, 7'b0010000); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL rm_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL rm_pending: got %b want %b", int_pending, 7'b0); end
        n_chk++; if (int_busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", int_busy); end
        // Stray ack/eoi in IDLE must not start a service phase
        int_ack = 1'b1;
        int_eoi = 1'b1;
        cyc();
        int_ack = 1'b0;
        int_eoi = 1'b0;
        n_chk++; if (int_busy !== 1'b0) begin n_err++; $display("FAIL rm_stray_ack: got %b want 0", int_busy); end
        for (int i = 0; i < 4; i++) cyc();
        n_chk++; if (int_vec !== 7'b0) begin n_err++; $display("FAIL rm_held_vec: got %b want %b", int_vec, 7'b0); end
        n_chk++; if (int_pending !== 7'b0) begin n_err++; $display("FAIL rm_held_pending: got %b want %b", int_pending, 7'b0); end
        dev_req = 7'b0;
        cyc();
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        test_reset();
        test_latency();
        test_priority();
        test_timeout();
        test_stable_and_withdraw();
        test_mask();
        test_set_wins();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
